hex_word_entry: RTL and testbench

- Input-side counterpart of the 32-bit hex display path. The operator enters a 32-bit word one hex digit at a time from a 4-bit switch nibble and three raw pushbuttons.
- The block synchronises, debounces and edge-detects the buttons, then builds the word in a shift register.
- It exposes the live working word for the 8-digit display and emits a committed word with a one-cycle valid pulse.
- It sits between board I/O and the processor's data-entry port or register-load logic.

---
 rtl/hex_word_entry.sv | 143 ++++++++++++++
 tb/tb_hex_word_entry.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hex_word_entry.sv
// hex_word_entry: builds a 32-bit word from hex digits entered on switches,
// using three debounced active-low pushbuttons (enter / back / commit).
// Ports: clk, rst (sync, active-high), sw[3:0], key_enter_n, key_back_n,
//   key_commit_n -> work (live word), value (committed), valid (1-cycle),
//   count (digits 0..8), full (count==8).
// Optional: define HEX_ENTRY_BLINK_EN to add cursor_blank[7:0].
module hex_word_entry #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int NDIGITS         = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [3:0]             sw,
   input  logic                   key_enter_n,
   input  logic                   key_back_n,
   input  logic                   key_commit_n,
   output logic [4*NDIGITS-1:0]   work,
   output logic [4*NDIGITS-1:0]   value,
   output logic                   valid,
   output logic [3:0]             count,
   output logic                   full
`ifdef HEX_ENTRY_BLINK_EN
   ,
   output logic [7:0]             cursor_blank
`endif
);

   localparam int W = 4 * NDIGITS;
   localparam logic [19:0] DB_MAX = 20'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0] FULL_CNT = 4'(NDIGITS);
   localparam logic [3:0] LAST_CNT = 4'(NDIGITS - 1);
   localparam int EN = 0;
   localparam int BK = 1;
   localparam int CM = 2;

   typedef enum logic [1:0] {
      S_EMPTY,
      S_EDIT,
      S_FULL,
      S_COMMIT
   } state_t;

   state_t      state;
   logic [2:0]  raw;
   logic [2:0]  sync1;
   logic [2:0]  sync2;
   logic [2:0]  acc;
   logic [2:0]  press;
   logic [19:0] cnt [3];

   assign raw = {key_commit_n, key_back_n, key_enter_n};

   // Sync, debounce and press detection for all three keys.
   // press is registered on the same edge that the accepted level falls.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 3'b111;
         sync2 <= 3'b111;
         acc   <= 3'b111;
         press <= 3'b000;
         for (int k = 0; k < 3; k++) cnt[k] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int k = 0; k < 3; k++) begin
            press[k] <= 1'b0;
            if (sync2[k] == acc[k]) begin
               cnt[k] <= '0;
            end else if (cnt[k] == DB_MAX) begin
               acc[k]   <= sync2[k];
               cnt[k]   <= '0;
               press[k] <= ~sync2[k];
            end else begin
               cnt[k] <= cnt[k] + 20'd1;
            end
         end
      end
   end

   // Entry FSM: commit > back > enter; presses in S_COMMIT are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_EMPTY;
         work  <= '0;
         value <= '0;
         valid <= 1'b0;
         count <= '0;
      end else begin
         valid <= 1'b0;
         unique case (state)
            S_COMMIT: begin
               work  <= '0;
               count <= '0;
               state <= S_EMPTY;
            end
            default: begin
               if (press[CM]) begin
                  value <= work;
                  valid <= 1'b1;
                  state <= S_COMMIT;
               end else if (press[BK]) begin
                  if (state != S_EMPTY) begin
                     work  <= {4'h0, work[W-1:4]};
                     count <= count - 4'd1;
                     state <= (count == 4'd1) ? S_EMPTY : S_EDIT;
                  end
               end else if (press[EN]) begin
                  if (state != S_FULL) begin
                     work  <= {work[W-5:0], sw};
                     count <= count + 4'd1;
                     state <= (count == LAST_CNT) ? S_FULL : S_EDIT;
                  end
               end
            end
         endcase
      end
   end

   assign full = (count == FULL_CNT);

`ifdef HEX_ENTRY_BLINK_EN
   logic [22:0] blink_cnt;

   always_ff @(posedge clk) begin
      if (rst) blink_cnt <= '0;
      else     blink_cnt <= blink_cnt + 23'd1;
   end

   // Entered digits shown, cursor digit blinks, rest blanked.
   always_comb begin
      cursor_blank = 8'h00;
      if (!full) begin
         for (int i = 0; i < 8; i++) begin
            if (4'(i) > count)
               cursor_blank[i] = 1'b1;
            else if (4'(i) == count)
               cursor_blank[i] = blink_cnt[22];
         end
      end
   end
`endif

endmodule

// File: tb/tb_hex_word_entry.sv
// tb_hex_word_entry: directed self-checking bench for hex_word_entry
// with DEBOUNCE_CYCLES=4.
module tb_hex_word_entry;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  sw = 4'h0;
   logic        key_enter_n = 1'b1;
   logic        key_back_n = 1'b1;
   logic        key_commit_n = 1'b1;
   logic [31:0] work;
   logic [31:0] value;
   logic        valid;
   logic [3:0]  count;
   logic        full;
`ifdef HEX_ENTRY_BLINK_EN
   logic [7:0]  cursor_blank;
`endif

   int tests = 0;
   int fails = 0;
   int vcount = 0;
   int vbase;

   always #5 clk = ~clk;

   hex_word_entry #(
      .DEBOUNCE_CYCLES(4),
      .NDIGITS(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sw(sw),
      .key_enter_n(key_enter_n),
      .key_back_n(key_back_n),
      .key_commit_n(key_commit_n),
      .work(work),
      .value(value),
      .valid(valid),
      .count(count),
      .full(full)
`ifdef HEX_ENTRY_BLINK_EN
      ,
      .cursor_blank(cursor_blank)
`endif
   );

   always @(negedge clk) if (valid) vcount <= vcount + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // k: 0 enter, 1 back, 2 commit
   task automatic push(input int k, input logic [3:0] d);
      sw = d;
      if (k == 0) key_enter_n = 1'b0;
      if (k == 1) key_back_n = 1'b0;
      if (k == 2) key_commit_n = 1'b0;
      cyc(8);
      key_enter_n = 1'b1;
      key_back_n = 1'b1;
      key_commit_n = 1'b1;
      cyc(8);
   endtask

   initial begin
      cyc(3);
      rst = 1'b0;
      cyc(100);
      chk("rst_work", work, 32'h0);
      chk("rst_value", value, 32'h0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_novalid", vcount, 0);
`ifdef HEX_ENTRY_BLINK_EN
      chk("rst_blank", 32'(cursor_blank), 32'hFE);
`endif

      for (int i = 1; i <= 8; i++) push(0, 4'(i));
      chk("fill_work", work, 32'h12345678);
      chk("fill_count", 32'(count), 32'd8);
      chk("fill_full", 32'(full), 32'd1);
`ifdef HEX_ENTRY_BLINK_EN
      chk("full_blank", 32'(cursor_blank), 32'h00);
`endif
      push(0, 4'hF);
      chk("ninth_work", work, 32'h12345678);
      chk("ninth_count", 32'(count), 32'd8);

      vbase = vcount;
      push(2, 4'h0);
      chk("c1_value", value, 32'h12345678);
      chk("c1_valid", vcount - vbase, 1);
      chk("c1_work", work, 32'h0);
      chk("c1_count", 32'(count), 32'd0);

      // bouncing press: only one append
      sw = 4'h3;
      for (int i = 0; i < 10; i++) begin
         key_enter_n = 1'b0;
         cyc(2);
         key_enter_n = 1'b1;
         cyc(2);
      end
      key_enter_n = 1'b0;
      cyc(12);
      key_enter_n = 1'b1;
      cyc(12);
      chk("bounce_count", 32'(count), 32'd1);
      chk("bounce_work", work, 32'h3);

      // 3-cycle glitch: too short to accept
      sw = 4'h9;
      key_enter_n = 1'b0;
      cyc(3);
      key_enter_n = 1'b1;
      cyc(12);
      chk("glitch_count", 32'(count), 32'd1);
      chk("glitch_work", work, 32'h3);
      push(2, 4'h0);

      push(0, 4'hA);
      push(0, 4'hB);
      push(0, 4'hC);
      chk("abc_work", work, 32'hABC);
      push(1, 4'h0);
      chk("back_work", work, 32'hAB);
      chk("back_count", 32'(count), 32'd2);
      vbase = vcount;
      push(2, 4'h0);
      chk("c2_value", value, 32'hAB);
      chk("c2_valid", vcount - vbase, 1);
      chk("c2_work", work, 32'h0);
      chk("c2_count", 32'(count), 32'd0);
      push(1, 4'h0);
      chk("back_empty_work", work, 32'h0);
      chk("back_empty_count", 32'(count), 32'd0);

      // commit and enter land together: commit wins
      push(0, 4'h1);
      push(0, 4'hF);
      chk("pre_sim_work", work, 32'h1F);
      vbase = vcount;
      sw = 4'h7;
      key_enter_n = 1'b0;
      key_commit_n = 1'b0;
      cyc(8);
      key_enter_n = 1'b1;
      key_commit_n = 1'b1;
      cyc(8);
      chk("sim_value", value, 32'h1F);
      chk("sim_valid", vcount - vbase, 1);
      chk("sim_count", 32'(count), 32'd0);
      chk("sim_work", work, 32'h0);

      // reset mid-entry
      push(0, 4'h5);
      push(0, 4'h6);
      chk("pre_rst_work", work, 32'h56);
      chk("pre_rst_count", 32'(count), 32'd2);
`ifdef HEX_ENTRY_BLINK_EN
      chk("blank_hi", 32'(cursor_blank[7:3]), 32'h1F);
      chk("blank_lo", 32'(cursor_blank[1:0]), 32'h0);
`endif
      vbase = vcount;
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(20);
      chk("mrst_work", work, 32'h0);
      chk("mrst_value", value, 32'h0);
      chk("mrst_count", 32'(count), 32'd0);
      chk("mrst_full", 32'(full), 32'd0);
      chk("mrst_novalid", vcount - vbase, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
